// File: rtl/master_clk_divider.sv
// Derives spi_sclk (clk_in/SCLK_DIV) and aclk (clk_in/ACLK_DIV) as registered 50 % duty clocks.
// Both counters restart together so every aclk edge lands on a spi_sclk falling edge.
module master_clk_divider #(
    parameter int SCLK_DIV = 4,
    parameter int ACLK_DIV = 64
) (
    input  logic clk_in,
    input  logic reset,
    output logic spi_sclk,
    output logic aclk
);

    localparam int S_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int A_W = (ACLK_DIV > 2) ? $clog2(ACLK_DIV) : 1;

    localparam logic [S_W-1:0] S_LAST = S_W'(SCLK_DIV / 2 - 1);
    localparam logic [A_W-1:0] A_LAST = A_W'(ACLK_DIV / 2 - 1);

    // Divisor legality is checked at elaboration so a bad configuration never builds.
    generate
        if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk
            $fatal(1, "master_clk_divider: SCLK_DIV=%0d must be even and >= 2", SCLK_DIV);
        end
        if (ACLK_DIV < 2 || (ACLK_DIV % 2) != 0) begin : g_bad_aclk
            $fatal(1, "master_clk_divider: ACLK_DIV=%0d must be even and >= 2", ACLK_DIV);
        end
        if (SCLK_DIV >= 1 && (ACLK_DIV % SCLK_DIV) != 0) begin : g_bad_ratio
            $fatal(1, "master_clk_divider: ACLK_DIV=%0d not a multiple of SCLK_DIV=%0d",
                   ACLK_DIV, SCLK_DIV);
        end
    endgenerate

    logic [S_W-1:0] cnt_s;
    logic [A_W-1:0] cnt_a;

    // Half-period counter for the SPI clock; toggling on wrap gives exact 50 % duty.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_s    <= '0;
            spi_sclk <= 1'b0;
        end else if (cnt_s == S_LAST) begin
            cnt_s    <= '0;
            spi_sclk <= ~spi_sclk;
        end else begin
            cnt_s    <= cnt_s + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_a <= '0;
            aclk  <= 1'b0;
        end else if (cnt_a == A_LAST) begin
            cnt_a <= '0;
            aclk  <= ~aclk;
        end else begin
            cnt_a <= cnt_a + 1'b1;
        end
    end

endmodule

// File: tb/tb_master_clk_divider.sv
// Self-checking bench for master_clk_divider: default instance plus a SCLK_DIV=2/ACLK_DIV=32 instance,
// both compared each cycle against an edge-count reference model.
module tb_master_clk_divider;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic spi_sclk, aclk;
    logic spi_sclk_f, aclk_f;

    int edge_k  = 0;
    int n_cmp   = 0;
    int n_err   = 0;

    master_clk_divider #(.SCLK_DIV(4), .ACLK_DIV(64)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .spi_sclk (spi_sclk),
        .aclk     (aclk)
    );

    master_clk_divider #(.SCLK_DIV(2), .ACLK_DIV(32)) dut_fast (
        .clk_in   (clk_in),
        .reset    (reset),
        .spi_sclk (spi_sclk_f),
        .aclk     (aclk_f)
    );

    always #5 clk_in = ~clk_in;

    // Edges since the last edge that sampled reset=1 (0 right after reset).
    always @(posedge clk_in) edge_k <= reset ? 0 : edge_k + 1;

    // An output with divisor div toggles every div/2 edges after release, starting low.
    function automatic logic ref_out(input int k, input int div);
        return ((k / (div / 2)) % 2) == 1;
    endfunction

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({spi_sclk, aclk, spi_sclk_f, aclk_f} !== 4'b0000) begin
                n_err++;
                $display("[TB] FAIL reset_low cycle %0d: got %b%b%b%b want 0000",
                         i, spi_sclk, aclk, spi_sclk_f, aclk_f);
            end
        end
    endtask

    task automatic test_power_up();
        int first_s = 0, first_a = 0, first_af = 0;
        logic ps = 1'b0, pa = 1'b0, paf = 1'b0;
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_cmp++;
            if (spi_sclk !== ref_out(edge_k, 4) || aclk !== ref_out(edge_k, 64)) begin
                n_err++;
                $display("[TB] FAIL powerup_seq edge %0d: got spi=%b aclk=%b want spi=%b aclk=%b",
                         edge_k, spi_sclk, aclk, ref_out(edge_k, 4), ref_out(edge_k, 64));
            end
            n_cmp++;
            if (spi_sclk_f !== ref_out(edge_k, 2) || aclk_f !== ref_out(edge_k, 32)) begin
                n_err++;
                $display("[TB] FAIL sweep_seq edge %0d: got spi=%b aclk=%b want spi=%b aclk=%b",
                         edge_k, spi_sclk_f, aclk_f, ref_out(edge_k, 2), ref_out(edge_k, 32));
            end
            if (spi_sclk === 1'b1 && ps === 1'b0 && first_s == 0) first_s = edge_k;
            if (aclk === 1'b1 && pa === 1'b0 && first_a == 0) first_a = edge_k;
            if (aclk_f === 1'b1 && paf === 1'b0 && first_af == 0) first_af = edge_k;
            ps = spi_sclk; pa = aclk; paf = aclk_f;
        end
        n_cmp++;
        if (first_s != 2) begin
            n_err++;
            $display("[TB] FAIL first_spi_rise: got edge %0d want edge 2", first_s);
        end
        n_cmp++;
        if (first_a != 32) begin
            n_err++;
            $display("[TB] FAIL first_aclk_rise: got edge %0d want edge 32", first_a);
        end
        n_cmp++;
        if (first_af != 16) begin
            n_err++;
            $display("[TB] FAIL sweep_first_aclk_rise: got edge %0d want edge 16", first_af);
        end
    endtask

    task automatic test_frequency();
        int rises = 0, run_s = 0, run_a = 0;
        bit seen_s = 0, seen_a = 0;
        logic ps = spi_sclk, pa = aclk, pf = spi_sclk_f;
        for (int i = 0; i < 1000; i++) begin
            tick();
            run_s++; run_a++;
            n_cmp++;
            if (spi_sclk !== ref_out(edge_k, 4) || aclk !== ref_out(edge_k, 64)) begin
                n_err++;
                $display("[TB] FAIL freq_seq edge %0d: got spi=%b aclk=%b want spi=%b aclk=%b",
                         edge_k, spi_sclk, aclk, ref_out(edge_k, 4), ref_out(edge_k, 64));
            end
            n_cmp++;
            if (spi_sclk_f !== ~pf) begin
                n_err++;
                $display("[TB] FAIL sweep_toggle edge %0d: got %b want %b", edge_k, spi_sclk_f, ~pf);
            end
            if (spi_sclk !== ps) begin
                if (spi_sclk === 1'b1) rises++;
                if (seen_s) begin
                    n_cmp++;
                    if (run_s != 2) begin
                        n_err++;
                        $display("[TB] FAIL spi_half_period edge %0d: got %0d cycles want 2",
                                 edge_k, run_s);
                    end
                end
                seen_s = 1; run_s = 0;
            end
            if (aclk !== pa) begin
                if (seen_a) begin
                    n_cmp++;
                    if (run_a != 32) begin
                        n_err++;
                        $display("[TB] FAIL aclk_half_period edge %0d: got %0d cycles want 32",
                                 edge_k, run_a);
                    end
                end
                seen_a = 1; run_a = 0;
            end
            ps = spi_sclk; pa = aclk; pf = spi_sclk_f;
        end
        n_cmp++;
        if (rises < 249 || rises > 251) begin
            n_err++;
            $display("[TB] FAIL spi_rise_count_10us: got %0d want 250+-1", rises);
        end
    endtask

    task automatic test_phase_lock();
        int rises = 0;
        bit armed = 0;
        logic ps = spi_sclk, pa = aclk;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (spi_sclk === 1'b1 && ps === 1'b0) rises++;
            if (aclk !== pa) begin
                n_cmp++;
                if (!(ps === 1'b1 && spi_sclk === 1'b0)) begin
                    n_err++;
                    $display("[TB] FAIL phase_lock edge %0d: spi %b->%b want 1->0",
                             edge_k, ps, spi_sclk);
                end
                if (aclk === 1'b1) begin
                    if (armed) begin
                        n_cmp++;
                        if (rises != 16) begin
                            n_err++;
                            $display("[TB] FAIL spi_per_aclk: got %0d rises want 16", rises);
                        end
                    end
                    armed = 1; rises = 0;
                end
            end
            ps = spi_sclk; pa = aclk;
        end
    endtask

    task automatic test_mid_reset();
        int first_s = 0, first_a = 0;
        logic ps = 1'b0, pa = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 43; i++) tick();
        n_cmp++;
        if (spi_sclk !== 1'b1 || aclk !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL pre_mid_reset edge %0d: got spi=%b aclk=%b want 1 1",
                     edge_k, spi_sclk, aclk);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({spi_sclk, aclk, spi_sclk_f, aclk_f} !== 4'b0000) begin
            n_err++;
            $display("[TB] FAIL mid_reset_low: got %b%b%b%b want 0000",
                     spi_sclk, aclk, spi_sclk_f, aclk_f);
        end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (spi_sclk === 1'b1 && ps === 1'b0 && first_s == 0) first_s = edge_k;
            if (aclk === 1'b1 && pa === 1'b0 && first_a == 0) first_a = edge_k;
            ps = spi_sclk; pa = aclk;
        end
        n_cmp++;
        if (first_s != 2 || first_a != 32) begin
            n_err++;
            $display("[TB] FAIL mid_reset_restart: got spi rise %0d aclk rise %0d want 2 and 32",
                     first_s, first_a);
        end
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 20; it++) begin
            int run_len = $urandom_range(150, 1);
            int pulse   = $urandom_range(3, 1);
            for (int i = 0; i < run_len; i++) begin
                tick();
                n_cmp++;
                if (spi_sclk !== ref_out(edge_k, 4) || aclk !== ref_out(edge_k, 64) ||
                    spi_sclk_f !== ref_out(edge_k, 2) || aclk_f !== ref_out(edge_k, 32)) begin
                    n_err++;
                    $display("[TB] FAIL random_seq iter %0d edge %0d: got %b%b%b%b want %b%b%b%b",
                             it, edge_k, spi_sclk, aclk, spi_sclk_f, aclk_f,
                             ref_out(edge_k, 4), ref_out(edge_k, 64),
                             ref_out(edge_k, 2), ref_out(edge_k, 32));
                end
            end
            reset = 1'b1;
            for (int i = 0; i < pulse; i++) tick();
            reset = 1'b0;
            n_cmp++;
            if ({spi_sclk, aclk, spi_sclk_f, aclk_f} !== 4'b0000) begin
                n_err++;
                $display("[TB] FAIL random_reset iter %0d: got %b%b%b%b want 0000",
                         it, spi_sclk, aclk, spi_sclk_f, aclk_f);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_power_up();
        test_frequency();
        test_phase_lock();
        test_mid_reset();
        test_random_resets();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
